// File: rtl/decode_stage_hazard_pipe.sv
// decode_stage_hazard_pipe: ID stage with register file, load-use stall FSM and registered ID/EX outputs.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle WB write to the read ports.
module decode_stage_hazard_pipe #(
  parameter int DATA_W            = 32,
  parameter int NUM_REGS          = 32,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ifid_valid,
  input  logic [31:0]       i_instruction,
  input  logic              i_flush,
  input  logic              i_wb_regwrite,
  input  logic [4:0]        i_wb_write_address,
  input  logic [DATA_W-1:0] i_wb_write_data,
  output logic              o_pc_write_enable,
  output logic              o_ifid_write_enable,
  output logic              o_idex_valid,
  output logic [5:0]        o_idex_opcode,
  output logic [5:0]        o_idex_funct,
  output logic [4:0]        o_idex_rs,
  output logic [4:0]        o_idex_rt,
  output logic [4:0]        o_idex_dest_reg,
  output logic [DATA_W-1:0] o_idex_rd1,
  output logic [DATA_W-1:0] o_idex_rd2,
  output logic [DATA_W-1:0] o_idex_imm
);
  localparam logic [5:0] LP_NREGS = 6'(NUM_REGS);
  typedef enum logic {RUN, STALL} state_t;
  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_regs [32];
  logic              r_valid, r_load;
  logic [5:0]        r_opcode, r_funct;
  logic [4:0]        r_rs, r_rt, r_dest;
  logic [DATA_W-1:0] r_rd1, r_rd2, r_imm;
  logic [5:0]        w_op;
  logic [4:0]        w_rs, w_rt, w_dest;
  logic              w_wb_ok, w_rs_ok, w_rt_ok, w_byp1, w_byp2;
  logic [DATA_W-1:0] w_rd1, w_rd2, w_imm;
  logic              w_zext, w_load, w_hazard, w_stall;
  assign w_op = i_instruction[31:26];
  assign w_rs = i_instruction[25:21];
  assign w_rt = i_instruction[20:16];
  assign w_wb_ok = i_wb_regwrite && i_wb_write_address != 5'd0 && {1'b0, i_wb_write_address} < LP_NREGS;
  assign w_rs_ok = w_rs != 5'd0 && {1'b0, w_rs} < LP_NREGS;
  assign w_rt_ok = w_rt != 5'd0 && {1'b0, w_rt} < LP_NREGS;
  // Entries at or above NUM_REGS are never written and never read, so they fold to constants.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wb_ok) begin
      r_regs[i_wb_write_address] <= i_wb_write_data;
    end
  end
`ifdef ID_WB_BYPASS_EN
  assign w_byp1 = i_wb_regwrite && i_wb_write_address == w_rs;
  assign w_byp2 = i_wb_regwrite && i_wb_write_address == w_rt;
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif
  assign w_rd1 = !w_rs_ok ? '0 : w_byp1 ? i_wb_write_data : r_regs[w_rs];
  assign w_rd2 = !w_rt_ok ? '0 : w_byp2 ? i_wb_write_data : r_regs[w_rt];
  assign w_dest = (w_op == 6'h00) ? i_instruction[15:11] :
                  (w_op == 6'h03) ? 5'd31 :
                  (w_op[5:3] == 3'b101 || w_op[5:2] == 4'b0001 || w_op == 6'h02) ? 5'd0 : w_rt;
  assign w_zext = w_op inside {6'h0C, 6'h0D, 6'h0E};
  assign w_imm  = w_zext ? {{(DATA_W-16){1'b0}}, i_instruction[15:0]}
                         : {{(DATA_W-16){i_instruction[15]}}, i_instruction[15:0]};
  assign w_load = w_op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  assign w_hazard = r_valid && r_load && r_dest != 5'd0 && i_ifid_valid && (w_rs == r_dest || w_rt == r_dest);
  // A flushed ID instruction is dead, so its hazard does not hold the front end.
  assign w_stall = (r_state == STALL) || (w_hazard && !i_flush);
  assign o_pc_write_enable   = i_rst_n && !w_stall;
  assign o_ifid_write_enable = o_pc_write_enable;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == STALL) begin
      w_cnt_nxt   = i_flush ? 3'd0 : r_cnt - 3'd1;
      w_state_nxt = (i_flush || r_cnt == 3'd1) ? RUN : STALL;
    end else if (w_hazard && !i_flush && LOAD_STALL_CYCLES > 1) begin
      w_state_nxt = STALL;
      w_cnt_nxt   = 3'(LOAD_STALL_CYCLES - 1);
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_load   <= 1'b0;
      r_opcode <= '0;
      r_funct  <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_dest   <= '0;
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_imm    <= '0;
    end else if (i_flush || w_stall || !i_ifid_valid) begin
      r_valid <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_valid  <= 1'b1;
      r_load   <= w_load;
      r_opcode <= w_op;
      r_funct  <= i_instruction[5:0];
      r_rs     <= w_rs;
      r_rt     <= w_rt;
      r_dest   <= w_dest;
      r_rd1    <= w_rd1;
      r_rd2    <= w_rd2;
      r_imm    <= w_imm;
    end
  end
  assign o_idex_valid    = r_valid;
  assign o_idex_opcode   = r_opcode;
  assign o_idex_funct    = r_funct;
  assign o_idex_rs       = r_rs;
  assign o_idex_rt       = r_rt;
  assign o_idex_dest_reg = r_dest;
  assign o_idex_rd1      = r_rd1;
  assign o_idex_rd2      = r_rd2;
  assign o_idex_imm      = r_imm;
endmodule

// File: doc/decode_stage_hazard_pipe.md
# decode_stage_hazard_pipe

Parametrised instruction-decode stage. It combines a reset-clearable register file, write-back bypass, a load-use hazard FSM with a configurable stall length, and a registered ID/EX pipeline register with bubble and flush insertion. It sits between the IF/ID register and the EX stage. It replaces the unregistered decode path, so EX consumes only registered ID/EX outputs.

## Interface
- DATA_W, 32: register and datapath width; the sign/zero extension output is DATA_W wide.
- NUM_REGS, 32: number of implemented registers (2..32). Reads of index ≥ NUM_REGS return 0; writes to those indices are ignored.
- LOAD_STALL_CYCLES, 1: stall length on a load-use hazard (1..7).
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- IFID_Valid  in  1  Instruction holds a real instruction.
- Instruction  in  32  IF/ID instruction word.
- Flush  in  1  branch/jump redirect from EX; kills the instruction currently in ID.
- WB_RegWrite  in  1  register-file write enable.
- WB_WriteAddress  in  5  write index.
- WB_WriteData  in  DATA_W  write data.
- PC_WriteEnable  out  1  combinational; 0 while stalling or in reset.
- IFID_WriteEnable  out  1  combinational; same value as PC_WriteEnable.
- IDEX_Valid  out  1  registered; ID/EX holds a real instruction.
- IDEX_Opcode  out  6  registered Instruction[31:26].
- IDEX_Funct  out  6  registered Instruction[5:0].
- IDEX_Rs, IDEX_Rt  out  5 each  registered source indices.
- IDEX_DestReg  out  5  registered destination index.
- IDEX_RD1, IDEX_RD2  out  DATA_W each  registered operands.
- IDEX_Imm  out  DATA_W  registered extended immediate.

## Operation
- Register file:
  - Register 0 always reads 0.
  - Writes commit on the clock edge when WB_RegWrite=1 and the address is in range.
  - All registers clear on reset.
- Read ports: rs = Instruction[25:21], rt = Instruction[20:16].
- Destination:
  - opcode 000000: rd = Instruction[15:11].
  - 000011 (jal): 31.
  - Stores (101xxx), branches (0001xx) and j (000010): 0.
  - All other opcodes: rt.
- Immediate: zero-extended for andi/ori/xori (001100/001101/001110); sign-extended from Instruction[15:0] for all other opcodes.
- Loads: opcodes 100000, 100001, 100011, 100100, 100101. The is-load flag is registered with ID/EX internally.
- Hazard (combinational): IDEX_Valid & IDEX-is-load & IDEX_DestReg≠0 & IFID_Valid & (rs==IDEX_DestReg | rt==IDEX_DestReg).
- FSM states:
  - RUN:
    - On hazard with Flush=0 and LOAD_STALL_CYCLES=1: stay in RUN and stall this cycle.
    - On hazard with Flush=0 and LOAD_STALL_CYCLES>1: go to STALL and load the counter with LOAD_STALL_CYCLES−1.
  - STALL:
    - Enables are 0 and a bubble is written each cycle.
    - The counter decrements each cycle; the FSM returns to RUN on the edge where the counter reaches 0.
    - Flush=1 returns the FSM to RUN immediately.
- ID/EX update, checked in this priority order each edge:
  1. Reset low: clear.
  2. Flush=1 or stalling or IFID_Valid=0: bubble (IDEX_Valid=0; other fields may hold any value).
  3. Otherwise: capture the decoded fields and operands with IDEX_Valid=1.
- Reset values: IDEX_Valid=0 and all IDEX_* fields=0; FSM=RUN; counter=0; all registers=0. PC_WriteEnable=IFID_WriteEnable=0 while Reset=0.

## Timing
- Decode latency is 1 cycle: an instruction in ID at edge N appears on the IDEX_* outputs after edge N.
- Enables drop in the same cycle as the hazard is detected. They stay low for exactly LOAD_STALL_CYCLES cycles, which also inserts LOAD_STALL_CYCLES bubbles.
- A WB write and an ID read of the same nonzero register in the same cycle resolve per ID_WB_BYPASS_EN.
- Flush has priority over a stall in the same cycle: a bubble is written and the enables return to 1 on the next cycle.
- Reset asserted mid-stall aborts the stall on that edge.

## Configuration
- ID_WB_BYPASS_EN defined:
  - If WB_RegWrite=1, WB_WriteAddress equals a read index, and that index is nonzero and in range, the read returns WB_WriteData in the same cycle.
  - IDEX_RD1/RD2 capture the new value.
- ID_WB_BYPASS_EN undefined:
  - Reads return the pre-write contents.
  - The instruction needs one extra cycle (or external forwarding) to see the new value.

## Test plan
- Reset: hold Reset=0 for 2 cycles with junk inputs -> IDEX_Valid=0, all IDEX_* fields=0, enables=0; after release, reads of r1..r31 return 0.
- Writeback then read: write r5=0xDEADBEEF, then decode add r3,r5,r0 -> next cycle IDEX_RD1=0xDEADBEEF, IDEX_RD2=0, IDEX_DestReg=3.
- Same-cycle write/read: WB writes r7=0x12 while ID reads r7 -> IDEX_RD1=0x12 with ID_WB_BYPASS_EN defined; the old value without it.
- Load-use: lw r4 followed by add r2,r4,r1 with LOAD_STALL_CYCLES=1 -> enables=0 for 1 cycle, one bubble, then add issues. Repeat with LOAD_STALL_CYCLES=3 -> 3 low cycles, 3 bubbles.
- Flush mid-stall: LOAD_STALL_CYCLES=3 and Flush=1 in the 2nd stall cycle -> bubble written, FSM back in RUN, enables=1 the next cycle.
- Immediate handling and range: ori with imm 0x8000 -> IDEX_Imm=0x00008000; addi with 0x8000 -> 0xFFFF8000. With NUM_REGS=16, writing r20 is ignored and reading r20 returns 0.
